// File: rtl/bbox_test_sequencer.sv
// Bounding-box test sequencer: issues box reads, tracks the closest hit, then holds the result for handshake.
// Optional feature: define BBOX_SEQ_HIT_STATS_EN to count hits per job on result_hit_cnt.
//
// state | meaning
// IDLE  | waiting for a job, start_ready high
// ISSUE | one box address per unstalled cycle
// DRAIN | waiting for in-flight intersect results
// DONE  | result_valid high until result_ready
//
// An empty job passes through DRAIN for one cycle, so its result appears two cycles after accept.
module bbox_test_sequencer #(
    parameter int IDX_W = 8,
    parameter int LAT   = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_in,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [IDX_W-1:0]    box_count,
    output logic [IDX_W-1:0]    box_rd_addr,
    output logic                box_rd_en,
    output logic                isect_stall,
    input  logic                isect_hit,
    input  logic signed [48:0]  isect_dist,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                result_hit,
    output logic [IDX_W-1:0]    result_idx,
    output logic [48:0]         result_dist,
    output logic [IDX_W:0]      result_hit_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           count_q, count_d;
    logic [IDX_W-1:0]           issue_q, issue_d;
    logic [LAT-1:0]             sr_vld_q, sr_vld_d;
    logic [LAT-1:0][IDX_W-1:0]  sr_idx_q, sr_idx_d;
    logic                       best_vld_q, best_vld_d;
    logic [IDX_W-1:0]           best_idx_q, best_idx_d;
    logic [48:0]                best_dist_q, best_dist_d;

    logic                       consume;
    logic                       take;
    logic                       pending;
    logic                       accept;
    logic [48:0]                hit_dist;

    assign isect_stall = stall_in;
    assign box_rd_addr = issue_q;
    assign accept      = (state_q == IDLE) && start_valid;
    assign consume     = !stall_in && sr_vld_q[LAT-1];
    // Origin inside the box reports as distance zero.
    assign hit_dist    = isect_dist[48] ? '0 : isect_dist;
    assign take        = consume && isect_hit && (!best_vld_q || (hit_dist < best_dist_q));

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            pending = pending | sr_vld_q[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        issue_d      = issue_q;
        best_vld_d   = best_vld_q;
        best_idx_d   = best_idx_q;
        best_dist_d  = best_dist_q;
        start_ready  = 1'b0;
        box_rd_en    = 1'b0;
        result_valid = 1'b0;

        if (take) begin
            best_vld_d  = 1'b1;
            best_idx_d  = sr_idx_q[LAT-1];
            best_dist_d = hit_dist;
        end

        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    count_d     = box_count;
                    issue_d     = '0;
                    best_vld_d  = 1'b0;
                    best_idx_d  = '0;
                    best_dist_d = '0;
                    state_d     = (box_count != '0) ? ISSUE : DRAIN;
                end
            end
            ISSUE: begin
                if (!stall_in) begin
                    box_rd_en = 1'b1;
                    if (issue_q == count_q - IDX_W'(1)) begin
                        state_d = DRAIN;
                    end else begin
                        issue_d = issue_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Only the output stage may still hold a result, and it is consumed this cycle.
                if (!stall_in && !pending) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        sr_vld_d = sr_vld_q;
        sr_idx_d = sr_idx_q;
        if (!stall_in) begin
            sr_vld_d[0] = box_rd_en;
            sr_idx_d[0] = issue_q;
            for (int i = 1; i < LAT; i++) begin
                sr_vld_d[i] = sr_vld_q[i-1];
                sr_idx_d[i] = sr_idx_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            issue_q     <= '0;
            sr_vld_q    <= '0;
            sr_idx_q    <= '0;
            best_vld_q  <= 1'b0;
            best_idx_q  <= '0;
            best_dist_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            issue_q     <= issue_d;
            sr_vld_q    <= sr_vld_d;
            sr_idx_q    <= sr_idx_d;
            best_vld_q  <= best_vld_d;
            best_idx_q  <= best_idx_d;
            best_dist_q <= best_dist_d;
        end
    end

    // Best registers are zero whenever no hit has been recorded.
    assign result_hit  = best_vld_q;
    assign result_idx  = best_idx_q;
    assign result_dist = best_dist_q;

`ifdef BBOX_SEQ_HIT_STATS_EN
    logic [IDX_W:0] hit_cnt_q, hit_cnt_d;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (accept) begin
            hit_cnt_d = '0;
        end else if (consume && isect_hit) begin
            hit_cnt_d = hit_cnt_q + (IDX_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign result_hit_cnt = hit_cnt_q;
`else
    logic unused_accept;
    assign unused_accept  = accept;
    assign result_hit_cnt = '0;
`endif

endmodule

// File: tb/tb_bbox_test_sequencer.sv
// Self-checking bench for bbox_test_sequencer: job-level reference model, intersect pipeline stand-in,
// directed scenarios with literal expectations and randomized jobs. Honours BBOX_SEQ_HIT_STATS_EN.
module tb_bbox_test_sequencer;
    localparam int IDX_W = 8;
    localparam int LAT   = 6;
`ifdef BBOX_SEQ_HIT_STATS_EN
    localparam int HC_ON = 1;
`else
    localparam int HC_ON = 0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               stall_in = 1'b0;
    logic               start_valid = 1'b0;
    logic               start_ready;
    logic [IDX_W-1:0]   box_count = '0;
    logic [IDX_W-1:0]   box_rd_addr;
    logic               box_rd_en;
    logic               isect_stall;
    logic               isect_hit = 1'b0;
    logic signed [48:0] isect_dist = '0;
    logic               result_valid;
    logic               result_ready = 1'b0;
    logic               result_hit;
    logic [IDX_W-1:0]   result_idx;
    logic [48:0]        result_dist;
    logic [IDX_W:0]     result_hit_cnt;

    bbox_test_sequencer #(.IDX_W(IDX_W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
        .start_valid(start_valid), .start_ready(start_ready), .box_count(box_count),
        .box_rd_addr(box_rd_addr), .box_rd_en(box_rd_en), .isect_stall(isect_stall),
        .isect_hit(isect_hit), .isect_dist(isect_dist),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_hit(result_hit), .result_idx(result_idx), .result_dist(result_dist),
        .result_hit_cnt(result_hit_cnt)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-job box table: what the intersect unit answers for each index.
    bit     tbl_hit  [256];
    longint tbl_dist [256];

    // Job-level reference model.
    bit     m_busy = 0;
    longint m_acc = 0, m_done = 0;
    int     m_issued = 0, m_cnt = 0;
    bit     m_ehit = 0;
    int     m_eidx = 0, m_ehcnt = 0;
    longint m_edist = 0;
    int     job_id = 0;

    // Signals sampled mid-cycle for the intersect pipeline stand-in.
    bit s_rden = 0, s_stall = 0;
    int s_addr = 0, s_id = 0;

    always @(negedge clk) begin
        bit exp_rd, exp_rv;
        longint d;
        if (!rst_n) begin
            chk("rst_start_ready", start_ready, 1);
            chk("rst_result_valid", result_valid, 0);
            chk("rst_box_rd_en", box_rd_en, 0);
            if (m_busy) job_id++;
            m_busy = 0;
            m_issued = 0;
        end else begin
            chk("isect_stall", isect_stall, stall_in);
            exp_rd = m_busy && (cyc > m_acc) && !stall_in && (m_issued < m_cnt);
            chk("box_rd_en", box_rd_en, exp_rd);
            if (exp_rd) chk("box_rd_addr", box_rd_addr, m_issued);
            chk("start_ready", start_ready, !m_busy);
            exp_rv = m_busy && (cyc >= m_done);
            chk("result_valid", result_valid, exp_rv);
            if (exp_rv) begin
                chk("result_hit", result_hit, m_ehit);
                chk("result_idx", result_idx, m_eidx);
                chk("result_dist", result_dist, m_edist);
                chk("result_hit_cnt", result_hit_cnt, m_ehcnt);
            end
            if (exp_rd) m_issued++;
            // Each stalled cycle between accept and result delays the result by one cycle.
            if (m_busy && stall_in && (cyc > m_acc) && (cyc < m_done)) m_done++;
            if (exp_rv && result_ready) begin
                m_busy = 0;
            end else if (!m_busy && start_valid) begin
                m_busy = 1;
                m_acc = cyc;
                m_cnt = box_count;
                m_issued = 0;
                m_done = (box_count == 0) ? cyc + 2 : cyc + box_count + LAT + 1;
                job_id++;
                m_ehit = 0; m_eidx = 0; m_edist = 0; m_ehcnt = 0;
                for (int i = 0; i < int'(box_count); i++) begin
                    if (tbl_hit[i]) begin
                        d = (tbl_dist[i] < 0) ? 0 : tbl_dist[i];
                        m_ehcnt++;
                        if (!m_ehit || d < m_edist) begin
                            m_ehit = 1; m_eidx = i; m_edist = d;
                        end
                    end
                end
                if (HC_ON == 0) m_ehcnt = 0;
            end
        end
        s_rden  = box_rd_en;
        s_addr  = box_rd_addr;
        s_stall = stall_in;
        s_id    = job_id;
    end

    // Intersect pipeline stand-in: LAT deep, frozen by stall; garbage whenever no live request is at the output.
    int env_vld [LAT];
    int env_idx [LAT];
    int env_id  [LAT];
    always @(posedge clk) begin
        int g;
        if (!s_stall) begin
            for (int i = LAT - 1; i > 0; i--) begin
                env_vld[i] = env_vld[i-1];
                env_idx[i] = env_idx[i-1];
                env_id[i]  = env_id[i-1];
            end
            env_vld[0] = s_rden;
            env_idx[0] = s_addr;
            env_id[0]  = s_id;
        end
        #1;
        if (env_vld[LAT-1] != 0 && env_id[LAT-1] == job_id) begin
            isect_hit = tbl_hit[env_idx[LAT-1]];
            if (tbl_hit[env_idx[LAT-1]]) isect_dist = 49'(tbl_dist[env_idx[LAT-1]]);
            else isect_dist = 49'($urandom_range(0, 5));
        end else begin
            g = int'($urandom_range(1, 9));
            isect_hit  = 1'($urandom_range(0, 1));
            isect_dist = -g;
        end
    end

    bit     r_hit;
    longint r_idx, r_dist, r_cnt, r_rel;

    task automatic clear_tbl();
        for (int i = 0; i < 256; i++) begin
            tbl_hit[i] = 0;
            tbl_dist[i] = 0;
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        stall_in = 1'b0;
        start_valid = 1'b0;
        result_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Called just after a rising edge. Returns first result_valid cycle relative to the accept cycle.
    task automatic run_job(input int cnt, input int st_start, input int st_len,
                           input int rdy_delay, input bit poke);
        longint acc, rel_now;
        bit ok;
        box_count = IDX_W'(cnt);
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        acc = cyc - 1;
        ok = 0;
        r_rel = -1;
        for (int k = 0; k < 400; k++) begin
            rel_now = cyc - acc;
            stall_in = (st_len > 0) && (rel_now >= st_start) && (rel_now < st_start + st_len);
            if (result_valid) begin
                ok = 1;
                r_rel = rel_now;
                break;
            end
            @(posedge clk); #1;
        end
        stall_in = 1'b0;
        chk("result_valid_timeout", ok, 1);
        if (!ok) begin
            do_reset();
        end else begin
            r_hit = result_hit; r_idx = result_idx; r_dist = result_dist; r_cnt = result_hit_cnt;
            for (int k = 0; k < rdy_delay; k++) begin
                if (poke) begin
                    start_valid = 1'($urandom_range(0, 1));
                    box_count = IDX_W'($urandom_range(0, 255));
                end
                @(posedge clk); #1;
            end
            start_valid = 1'b0;
            result_ready = 1'b1;
            @(posedge clk); #1;
            result_ready = 1'b0;
        end
    endtask

    initial begin
        int cnt, st_start, st_len, dv;
        clear_tbl();
        #23 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_result_hit", result_hit, 0);
        chk("reset_result_idx", result_idx, 0);
        chk("reset_result_dist", result_dist, 0);
        chk("reset_start_ready", start_ready, 1);

        // Empty job.
        run_job(0, 0, 0, 0, 0);
        chk("cnt0_latency", r_rel, 2);
        chk("cnt0_hit", r_hit, 0);
        chk("cnt0_idx", r_idx, 0);
        chk("cnt0_dist", r_dist, 0);

        // Two hits, the later one closer.
        clear_tbl();
        tbl_hit[1] = 1; tbl_dist[1] = 500;
        tbl_hit[3] = 1; tbl_dist[3] = 200;
        run_job(4, 0, 0, 1, 0);
        chk("c4_latency", r_rel, 11);
        chk("c4_hit", r_hit, 1);
        chk("c4_idx", r_idx, 3);
        chk("c4_dist", r_dist, 200);
        chk("c4_hitcnt", r_cnt, 2 * HC_ON);

        // Ties keep the lowest index.
        clear_tbl();
        for (int i = 0; i < 3; i++) begin tbl_hit[i] = 1; tbl_dist[i] = 100; end
        run_job(3, 0, 0, 0, 0);
        chk("tie_idx", r_idx, 0);
        chk("tie_dist", r_dist, 100);

        // Negative distance clamps to zero and wins.
        tbl_dist[2] = -40;
        run_job(3, 0, 0, 0, 0);
        chk("neg_idx", r_idx, 2);
        chk("neg_dist", r_dist, 0);

        // Three-cycle stall mid-issue.
        clear_tbl();
        tbl_hit[2] = 1; tbl_dist[2] = 77;
        tbl_hit[4] = 1; tbl_dist[4] = 90;
        run_job(5, 3, 3, 0, 0);
        chk("stall_latency", r_rel, 15);
        chk("stall_idx", r_idx, 2);
        chk("stall_dist", r_dist, 77);

        // Result held ten cycles while start requests are ignored.
        run_job(5, 0, 0, 10, 1);
        chk("hold_idx", r_idx, 2);

        // Reset mid-drain, then a short job that must ignore stale results.
        clear_tbl();
        for (int i = 0; i < 8; i++) begin tbl_hit[i] = 1; tbl_dist[i] = 5; end
        box_count = 8'd8;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        do_reset();
        chk("rst_mid_valid", result_valid, 0);
        chk("rst_mid_ready", start_ready, 1);
        clear_tbl();
        tbl_hit[1] = 1; tbl_dist[1] = 50;
        run_job(2, 0, 0, 0, 0);
        chk("post_rst_latency", r_rel, 9);
        chk("post_rst_hit", r_hit, 1);
        chk("post_rst_idx", r_idx, 1);
        chk("post_rst_dist", r_dist, 50);

        // Randomized jobs.
        for (int j = 0; j < 40; j++) begin
            clear_tbl();
            cnt = int'($urandom_range(0, 24));
            for (int i = 0; i < cnt; i++) begin
                tbl_hit[i] = 1'($urandom_range(0, 1));
                dv = int'($urandom_range(0, 60));
                tbl_dist[i] = dv - 10;
            end
            st_len = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
            st_start = int'($urandom_range(1, cnt + LAT));
            run_job(cnt, st_start, st_len, int'($urandom_range(0, 3)), 1);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
